// File: rtl/mem_arbiter.sv
// Shares one memory bus port between fetch (IF) and load/store (MEM); one transaction in flight, round-robin on ties.
// Latency: accept->notify >= 2 cycles; bus_req_o held until bus_gnt_i, requesters held via valid until notify.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                if_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_notify_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_valid_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_be_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                mem_notify_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  input  logic                flush_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q, req_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   drop_q, drop_d;
  logic   if_eff;
  logic   pick_mem;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    last_d       = last_q;
    drop_d       = drop_q;
    if_notify_o  = 1'b0;
    mem_notify_o = 1'b0;
    // A redirect in the arbitration cycle makes the fetch request stale
    if_eff       = if_valid_i && !flush_i;
    pick_mem     = mem_valid_i && (!if_eff || (last_q == OWN_IF));

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (pick_mem) begin
          owner_d     = OWN_MEM;
          last_d      = OWN_MEM;
          req_d.we    = mem_we_i;
          req_d.be    = mem_be_i;
          req_d.addr  = mem_addr_i;
          req_d.wdata = mem_wdata_i;
          state_d     = REQ;
        end else if (if_eff) begin
          owner_d     = OWN_IF;
          last_d      = OWN_IF;
          req_d.we    = 1'b0;
          req_d.be    = '1;
          req_d.addr  = if_addr_i;
          req_d.wdata = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (flush_i && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (bus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (flush_i && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (bus_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_MEM) mem_notify_o = 1'b1;
          else if (!drop_q && !flush_i) if_notify_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = req_q.we;
  assign bus_be_o    = req_q.be;
  assign bus_addr_o  = req_q.addr;
  assign bus_wdata_o = req_q.wdata;
  assign if_rdata_o  = bus_rdata_i;
  assign mem_rdata_o = bus_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_notify_o;
  logic [31:0] if_rdata_o;
  logic        mem_valid_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_notify_o;
  logic [31:0] mem_rdata_o;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by the bus responder
  bit          b_ok;
  bit          b_proto;
  logic [68:0] b_cap;
  int          b_nif;
  int          b_nmem;
  logic [31:0] b_ifrd;
  logic [31:0] b_memrd;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i),
    .if_notify_o(if_notify_o), .if_rdata_o(if_rdata_o),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_notify_o(mem_notify_o), .mem_rdata_o(mem_rdata_o),
    .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    if_valid_i = 1'b0; if_addr_i = '0;
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_be_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    flush_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic sample_notify();
    if (if_notify_o === 1'b1) begin b_nif++; b_ifrd = if_rdata_o; end
    if (mem_notify_o === 1'b1) begin b_nmem++; b_memrd = mem_rdata_o; end
  endtask

  // Bus responder: waits for a request, grants after gnt_dly cycles, answers rv_dly cycles later.
  // fmode: 0 none, 1 flush in first WAIT cycle, 2 flush with rvalid, 3 flush in first REQ cycle.
  task automatic do_bus(input int gnt_dly, input int rv_dly, input logic [31:0] rd, input int fmode);
    b_ok = 1'b0; b_proto = 1'b1; b_nif = 0; b_nmem = 0; b_ifrd = '0; b_memrd = '0; b_cap = '0;
    for (int i = 0; i < 20 && !b_ok; i++) begin
      @(negedge clk); #1;
      sample_notify();
      if (bus_req_o === 1'b1) b_ok = 1'b1;
    end
    if (!b_ok) return;
    b_cap = {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o};
    flush_i = (fmode == 3);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk); flush_i = 1'b0; #1;
      sample_notify();
      if (bus_req_o !== 1'b1 || {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== b_cap) b_proto = 1'b0;
    end
    bus_gnt_i = 1'b1;
    for (int j = 0; j <= rv_dly; j++) begin
      @(negedge clk);
      bus_gnt_i    = 1'b0;
      flush_i      = (fmode == 1 && j == 0) || (fmode == 2 && j == rv_dly);
      bus_rvalid_i = (j == rv_dly);
      bus_rdata_i  = (j == rv_dly) ? rd : 32'h0;
      #1;
      if (bus_req_o !== 1'b0) b_proto = 1'b0;
      sample_notify();
    end
    @(negedge clk);
    bus_rvalid_i = 1'b0; flush_i = 1'b0; bus_rdata_i = '0;
    #1;
    sample_notify();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({bus_req_o, if_notify_o, mem_notify_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 000", {bus_req_o, if_notify_o, mem_notify_o});
    end
    n_checks++;
    if ({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== 69'h0) begin
      n_fail++; $display("FAIL reset_fields got %h exp 0", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o});
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    if_valid_i = 1'b1; if_addr_i = 32'h100;
    @(negedge clk); #1;
    n_checks++;
    if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL fetch_req got %h exp %h", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100});
    end
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({if_notify_o, mem_notify_o, if_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_notify got %h exp %h", {if_notify_o, mem_notify_o, if_rdata_o}, {2'b10, 32'hDEADBEEF});
    end
    @(negedge clk);
    bus_rvalid_i = 1'b0; if_valid_i = 1'b0; bus_rdata_i = '0;
    #1;
    n_checks++;
    if ({if_notify_o, mem_notify_o, bus_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL fetch_after got %b exp 000", {if_notify_o, mem_notify_o, bus_req_o});
    end
  endtask

  task automatic test_store();
    apply_reset();
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'h3; mem_addr_i = 32'h2000; mem_wdata_i = 32'h1234;
    do_bus(4, 1, 32'h0, 0);
    mem_valid_i = 1'b0;
    n_checks++;
    if (!b_ok || !b_proto || b_cap !== {1'b1, 4'h3, 32'h2000, 32'h1234}) begin
      n_fail++; $display("FAIL store_fields ok=%0d stable=%0d got %h exp %h", b_ok, b_proto, b_cap, {1'b1, 4'h3, 32'h2000, 32'h1234});
    end
    n_checks++;
    if (b_nmem != 1 || b_nif != 0) begin
      n_fail++; $display("FAIL store_notify got mem=%0d if=%0d exp mem=1 if=0", b_nmem, b_nif);
    end
  endtask

  task automatic test_contention();
    bit exp_mem;
    bit got_mem;
    apply_reset();
    if_addr_i = 32'h1000; mem_addr_i = 32'h2000; mem_be_i = 4'hF;
    if_valid_i = 1'b1; mem_valid_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_mem = (t % 2 == 0);
      do_bus(t % 2, 0, 32'hA000 + t, 0);
      got_mem = (b_cap[63:32] == 32'h2000);
      n_checks++;
      if (!b_ok || got_mem != exp_mem) begin
        n_fail++; $display("FAIL contention_order t=%0d ok=%0d got_mem=%0d exp_mem=%0d", t, b_ok, got_mem, exp_mem);
      end
      n_checks++;
      if (b_nmem != int'(exp_mem) || b_nif != int'(!exp_mem)) begin
        n_fail++; $display("FAIL contention_notify t=%0d got mem=%0d if=%0d exp mem=%0d if=%0d", t, b_nmem, b_nif, exp_mem, !exp_mem);
      end
      if (got_mem) mem_valid_i = 1'b0; else if_valid_i = 1'b0;
      @(negedge clk);
      if_valid_i = 1'b1; mem_valid_i = 1'b1;
    end
    if_valid_i = 1'b0; mem_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    // Redirect in the arbitration cycle: fetch not accepted that cycle
    if_valid_i = 1'b1; if_addr_i = 32'h400; flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle got req=%b exp 0", bus_req_o);
    end
    do_bus(0, 2, 32'h11111111, 1);
    n_checks++;
    if (!b_ok || !b_proto || b_nif != 0) begin
      n_fail++; $display("FAIL flush_wait ok=%0d proto=%0d got if=%0d exp 0", b_ok, b_proto, b_nif);
    end
    if_addr_i = 32'h404;
    do_bus(0, 0, 32'h22222222, 0);
    n_checks++;
    if (!b_ok || b_nif != 1 || b_ifrd !== 32'h22222222 || b_cap[63:32] !== 32'h404) begin
      n_fail++; $display("FAIL flush_next got if=%0d rd=%h addr=%h exp 1 22222222 404", b_nif, b_ifrd, b_cap[63:32]);
    end
    if_addr_i = 32'h408;
    do_bus(1, 1, 32'h33333333, 2);
    if_valid_i = 1'b0;
    n_checks++;
    if (!b_ok || b_nif != 0) begin
      n_fail++; $display("FAIL flush_rvalid got if=%0d exp 0", b_nif);
    end
    mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_addr_i = 32'h3000;
    do_bus(0, 1, 32'h44444444, 1);
    mem_valid_i = 1'b0;
    n_checks++;
    if (!b_ok || b_nmem != 1 || b_memrd !== 32'h44444444) begin
      n_fail++; $display("FAIL flush_mem got mem=%0d rd=%h exp 1 44444444", b_nmem, b_memrd);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    if_valid_i = 1'b1; if_addr_i = 32'h300;
    @(negedge clk);
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0; rst_i = 1'b1; if_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0; #1;
    n_checks++;
    if ({bus_req_o, if_notify_o, mem_notify_o} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_state got %b exp 000", {bus_req_o, if_notify_o, mem_notify_o});
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55555555;
    #1;
    n_checks++;
    if ({if_notify_o, mem_notify_o} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_stray got %b exp 00", {if_notify_o, mem_notify_o});
    end
    @(negedge clk);
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    if_valid_i = 1'b1; if_addr_i = 32'h500;
    mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_addr_i = 32'h600;
    do_bus(0, 0, 32'h0, 0);
    if_valid_i = 1'b0; mem_valid_i = 1'b0;
    n_checks++;
    if (!b_ok || b_cap[63:32] !== 32'h600) begin
      n_fail++; $display("FAIL rstmid_lastgrant got addr=%h exp 600", b_cap[63:32]);
    end
  endtask

  // Reference: a tie goes to whichever side did not win the previous transaction;
  // a fetch touched by a redirect after acceptance never notifies.
  task automatic test_random();
    bit          last_mem;
    bit          w_mem;
    bit          first_mem;
    int          sc;
    int          fm;
    int          nserve;
    logic [31:0] ia, ma, mwd, rd;
    logic        mwe;
    logic [3:0]  mbe;
    logic [68:0] exp_cap;
    apply_reset();
    last_mem = 1'b0;
    for (int it = 0; it < 30; it++) begin
      sc  = $urandom_range(0, 2);
      ia  = $urandom & 32'hFFFF_FFFC;
      ma  = $urandom;
      mwd = $urandom;
      mwe = 1'($urandom_range(0, 1));
      mbe = 4'($urandom_range(1, 15));
      if_addr_i = ia; mem_addr_i = ma; mem_wdata_i = mwd; mem_we_i = mwe; mem_be_i = mbe;
      if_valid_i  = (sc != 1);
      mem_valid_i = (sc != 0);
      first_mem = (sc == 1) || (sc == 2 && !last_mem);
      nserve = (sc == 2) ? 2 : 1;
      for (int k = 0; k < nserve; k++) begin
        w_mem = (k == 0) ? first_mem : !first_mem;
        fm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        rd = $urandom;
        do_bus($urandom_range(0, 3), $urandom_range(0, 2), rd, fm);
        exp_cap = w_mem ? {mwe, mbe, ma, mwd} : {1'b0, 4'hF, ia, 32'h0};
        n_checks++;
        if (!b_ok || !b_proto || b_cap !== exp_cap) begin
          n_fail++; $display("FAIL rand_fields it=%0d k=%0d ok=%0d proto=%0d got %h exp %h", it, k, b_ok, b_proto, b_cap, exp_cap);
        end
        n_checks++;
        if (w_mem && (b_nmem != 1 || b_nif != 0 || b_memrd !== rd)) begin
          n_fail++; $display("FAIL rand_mem it=%0d got mem=%0d if=%0d rd=%h exp 1 0 %h", it, b_nmem, b_nif, b_memrd, rd);
        end else if (!w_mem && fm != 0 && (b_nif != 0 || b_nmem != 0)) begin
          n_fail++; $display("FAIL rand_drop it=%0d got if=%0d mem=%0d exp 0 0", it, b_nif, b_nmem);
        end else if (!w_mem && fm == 0 && (b_nif != 1 || b_nmem != 0 || b_ifrd !== rd)) begin
          n_fail++; $display("FAIL rand_if it=%0d got if=%0d mem=%0d rd=%h exp 1 0 %h", it, b_nif, b_nmem, b_ifrd, rd);
        end
        last_mem = w_mem;
        if (w_mem) mem_valid_i = 1'b0; else if_valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
